// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the 2D FIR filter front end: pixel/address widths,
// kernel size, the line-buffer controller state encoding and a saturating
// increment helper for 16-bit event counters.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int PIX_W     = 8;   // pixel width
    localparam int KERNEL    = 3;   // window is KERNEL x KERNEL
    localparam int LB_ADDR_W = 11;  // line-buffer address width (dp_bram)
    localparam int ROW_W     = 11;  // row counter width
    localparam int STAT_W    = 16;  // statistics counter width

    // Frame sequencing states of the line-buffer controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a start-of-frame beat
        FILL = 2'd1,   // rows 0..KERNEL-2: buffers filling, no windows
        RUN  = 2'd2,   // rows KERNEL-1..IMG_H-1: windows produced
        DONE = 2'd3    // one cycle after the last pixel of a frame
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/lbc_pos_cnt.sv
// -----------------------------------------------------------------------------
// lbc_pos_cnt
// Raster position tracker for the line-buffer controller. Holds the position
// of the next pixel expected in the frame and presents the position of the
// beat currently offered: (0,0) when that beat carries start-of-frame,
// otherwise the held position. Advancing wraps the column at IMG_W-1 into
// the next row and wraps the whole frame back to (0,0) after the last pixel.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   adv         : a pixel at beat_col/beat_row is being written this cycle
//   sof         : the offered beat is a start-of-frame (reloads to 0,0)
//   beat_col    : column of the offered beat
//   beat_row    : row of the offered beat
//   col_end     : beat is the last column of its line
//   last        : beat is the last pixel of the frame
// -----------------------------------------------------------------------------
module lbc_pos_cnt
    import fir_pkg::*;
#(
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int ADDR_W = LB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              sof,
    output logic [ADDR_W-1:0] beat_col,
    output logic [ROW_W-1:0]  beat_row,
    output logic              col_end,
    output logic              last
);

    logic [ADDR_W-1:0] col_q;
    logic [ROW_W-1:0]  row_q;

    // A start-of-frame beat is always pixel (0,0), whatever was held.
    assign beat_col = sof ? '0 : col_q;
    assign beat_row = sof ? '0 : row_q;

    assign col_end = (beat_col == ADDR_W'(IMG_W - 1));
    assign last    = col_end && (beat_row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv) begin
            if (last) begin
                col_q <= '0;
                row_q <= '0;
            end else if (col_end) begin
                col_q <= '0;
                row_q <= beat_row + ROW_W'(1);
            end else begin
                col_q <= beat_col + ADDR_W'(1);
                row_q <= beat_row;
            end
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// line_buf_ctrl
// Sequences the two line buffers feeding the 3x3 window of the 2D FIR core.
// Buffer 0 stores the incoming line; buffer 1 stores the line read out of
// buffer 0. Both buffers are read-first dual-port RAMs whose two ports share
// one address, so a single write also returns the previous line's pixel at
// that column one cycle later.
//
// Handshake: a beat transfers in a cycle where in_valid && in_ready. in_ready
// is low only during the single DONE cycle after the last pixel of a frame;
// in_valid may drop at any time and no beat then occurs. There is no
// backpressure from the filter core: every flagged window column is consumed
// the cycle it is presented.
//
// Timing of a pixel (c, r) accepted in cycle T:
//   T   : lb0_we=1, lb0_addr=c, lb0_din=pixel  (lb0 dout_b at T+1 = row r-1)
//   T+1 : lb1_we=1, lb1_addr=c                (lb1 dout at T+2 = row r-2)
//         pix_d=pixel, win_valid=(r>=2 && c>=2), col=c, row=r
// The core registers pix_d and lb0 dout once more to line up with lb1 dout.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake
//   in_sof, in_data      : start-of-frame marker and pixel value
//   lb0_we/addr/din      : buffer 0 write enable, shared address, write data
//   lb1_we/addr          : buffer 1 write enable, shared address
//                          (buffer 1 write data is buffer 0 dout_b)
//   pix_d                : in_data aligned with buffer 0 dout_b
//   win_valid, col, row  : newest window column is valid, and its position
//   frame_done           : one-cycle pulse after the last pixel of a frame
//   resync               : one-cycle pulse when in_sof arrives mid-frame
//
// Optional build macro LINE_BUF_CTRL_STATS_EN adds drop_cnt (IDLE beats
// discarded) and resync_cnt (mid-frame start-of-frame events), both 16-bit
// saturating and cleared only by rst_n.
// -----------------------------------------------------------------------------
module line_buf_ctrl
    import fir_pkg::*;
#(
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int ADDR_W = LB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [PIX_W-1:0]  in_data,
    output logic              lb0_we,
    output logic [ADDR_W-1:0] lb0_addr,
    output logic [PIX_W-1:0]  lb0_din,
    output logic              lb1_we,
    output logic [ADDR_W-1:0] lb1_addr,
    output logic [PIX_W-1:0]  pix_d,
    output logic              win_valid,
    output logic [ADDR_W-1:0] col,
    output logic [ROW_W-1:0]  row,
    output logic              frame_done,
    output logic              resync
`ifdef LINE_BUF_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] drop_cnt,
    output logic [STAT_W-1:0] resync_cnt
`endif
);

    state_t state;
    state_t state_nxt;

    logic              beat;       // handshake completes this cycle
    logic              sof_beat;   // the beat carries start-of-frame
    logic              mid_frame;  // a frame is in progress
    logic              wr;         // the beat is written as a frame pixel
    logic              mid_sof;    // start-of-frame interrupting a frame
    logic              pos_last;
    logic              pos_col_end;
    logic [ADDR_W-1:0] beat_col;
    logic [ROW_W-1:0]  beat_row;
    logic              win_now;

    assign in_ready  = (state != DONE);
    assign beat      = in_valid && in_ready;
    assign sof_beat  = beat && in_sof;
    assign mid_frame = (state == FILL) || (state == RUN);
    // In IDLE only a start-of-frame beat opens a frame; others are dropped.
    assign wr        = beat && (in_sof || mid_frame);
    assign mid_sof   = sof_beat && mid_frame;

    lbc_pos_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_pos_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (wr),
        .sof      (sof_beat),
        .beat_col (beat_col),
        .beat_row (beat_row),
        .col_end  (pos_col_end),
        .last     (pos_last)
    );

    // Buffer 0 is driven in the cycle of the beat so its read-first port
    // returns the previous line's pixel at the same column one cycle later.
    assign lb0_we   = wr;
    assign lb0_addr = beat_col;
    assign lb0_din  = in_data;

    // A window column exists once KERNEL-1 earlier rows and columns exist.
    // Gating on the beat's own position (reloaded to 0,0 on start-of-frame)
    // keeps stale buffer contents from ever being flagged after a resync.
    assign win_now = wr
                  && (beat_row >= ROW_W'(KERNEL - 1))
                  && (beat_col >= ADDR_W'(KERNEL - 1));

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr) begin
                    state_nxt = FILL;
                end
            end
            FILL, RUN: begin
                if (wr) begin
                    if (in_sof) begin
                        state_nxt = FILL;
                    end else if (pos_last) begin
                        state_nxt = DONE;
                    end else if (pos_col_end &&
                                 (beat_row == ROW_W'(KERNEL - 2))) begin
                        state_nxt = RUN;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign frame_done = (state == DONE);

    // ------------------------------------------------------------------
    // T+1 outputs: buffer 1 write, aligned pixel, window flag and position.
    // These complete for the previous beat even if the current beat resyncs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb1_we    <= 1'b0;
            lb1_addr  <= '0;
            pix_d     <= '0;
            win_valid <= 1'b0;
            col       <= '0;
            row       <= '0;
            resync    <= 1'b0;
        end else begin
            lb1_we    <= wr;
            win_valid <= win_now;
            resync    <= mid_sof;
            if (wr) begin
                lb1_addr <= beat_col;
                pix_d    <= in_data;
                col      <= beat_col;
                row      <= beat_row;
            end
        end
    end

`ifdef LINE_BUF_CTRL_STATS_EN
    // ------------------------------------------------------------------
    // Event statistics
    // ------------------------------------------------------------------
    logic idle_drop;
    assign idle_drop = beat && !in_sof && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt   <= '0;
            resync_cnt <= '0;
        end else begin
            if (idle_drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (mid_sof) begin
                resync_cnt <= sat_inc(resync_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buf_ctrl
// Bench for line_buf_ctrl with a 4x4 image. Read-first dual-port RAM models
// stand in for the two line buffers so the window taps can be checked.
// The reference model tracks the frame as a linear pixel index and a stored
// image array; windows are the pixel and the two pixels directly above it.
// Build with LINE_BUF_CTRL_STATS_EN defined to also check the statistics.
// -----------------------------------------------------------------------------
module tb_line_buf_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 11;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [7:0]    in_data;
    logic          lb0_we;
    logic [AW-1:0] lb0_addr;
    logic [7:0]    lb0_din;
    logic          lb1_we;
    logic [AW-1:0] lb1_addr;
    logic [7:0]    pix_d;
    logic          win_valid;
    logic [AW-1:0] col;
    logic [10:0]   row;
    logic          frame_done;
    logic          resync;
`ifdef LINE_BUF_CTRL_STATS_EN
    logic [15:0]   drop_cnt;
    logic [15:0]   resync_cnt;
`endif

    always #5 clk = ~clk;

    line_buf_ctrl #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .lb0_we     (lb0_we),
        .lb0_addr   (lb0_addr),
        .lb0_din    (lb0_din),
        .lb1_we     (lb1_we),
        .lb1_addr   (lb1_addr),
        .pix_d      (pix_d),
        .win_valid  (win_valid),
        .col        (col),
        .row        (row),
        .frame_done (frame_done),
        .resync     (resync)
`ifdef LINE_BUF_CTRL_STATS_EN
        ,
        .drop_cnt   (drop_cnt),
        .resync_cnt (resync_cnt)
`endif
    );

    // Read-first line buffer models (both ports share one address).
    logic [7:0] m0 [0:2047];
    logic [7:0] m1 [0:2047];
    logic [7:0] lb0_dout;
    logic [7:0] lb1_dout;

    always @(posedge clk) begin
        if (lb0_we) m0[lb0_addr] <= lb0_din;
        lb0_dout <= m0[lb0_addr];
        if (lb1_we) m1[lb1_addr] <= lb0_dout;
        lb1_dout <= m1[lb1_addr];
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] exp_q[$];          // expected {pix, row-1, row-2} taps
    logic [21:0] win_seen[$];       // {row, col} of each flagged window
    logic [21:0] exp_win[4];
    bit          tap_pend = 1'b0;
    logic [7:0]  tap0, tap1;
    logic [23:0] last_taps = '0;

    // Reference model
    bit          m_in_frame  = 1'b0;
    int          m_pos       = 0;
    bit          m_done_pend = 1'b0;
    logic [7:0]  m_pix       = '0;
    int          m_drop      = 0;
    int          m_resync    = 0;
    int          m_frames    = 0;
    logic [7:0]  img [0:W*H-1];

    // Samples from the last cycle() call
    logic        s_ready, s_we;
    logic [AW-1:0] s_addr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_in_frame  = 1'b0;
        m_pos       = 0;
        m_done_pend = 1'b0;
        m_pix       = '0;
        m_drop      = 0;
        m_resync    = 0;
        tap_pend    = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_in_ready"},   in_ready, 1);
        check({p, "_lb0_we"},     lb0_we, 0);
        check({p, "_lb0_addr"},   lb0_addr, 0);
        check({p, "_lb1_we"},     lb1_we, 0);
        check({p, "_lb1_addr"},   lb1_addr, 0);
        check({p, "_pix_d"},      pix_d, 0);
        check({p, "_win_valid"},  win_valid, 0);
        check({p, "_col"},        col, 0);
        check({p, "_row"},        row, 0);
        check({p, "_frame_done"}, frame_done, 0);
        check({p, "_resync"},     resync, 0);
`ifdef LINE_BUF_CTRL_STATS_EN
        check({p, "_drop_cnt"},   drop_cnt, 0);
        check({p, "_resync_cnt"}, resync_cnt, 0);
`endif
    endtask

    // ------------------------------------------------------------------
    // Driver: one clock cycle, entered and left at posedge+1.
    // ------------------------------------------------------------------
    task automatic cycle(input bit v, input bit sof, input logic [7:0] d);
        bit ready_e, beat, wr, win_e, res_e, fd_e;
        int c_e, r_e;
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        ready_e  = !m_done_pend;
        beat     = v && ready_e;
        wr = 0; win_e = 0; res_e = 0; fd_e = 0; c_e = 0; r_e = 0;
        m_done_pend = 1'b0;
        if (beat) begin
            if (sof) begin
                res_e = m_in_frame;
                if (m_in_frame) m_resync++;
                m_in_frame = 1'b1;
                m_pos = 0;
                wr = 1;
            end else if (m_in_frame) begin
                wr = 1;
            end else begin
                m_drop++;
            end
        end
        if (wr) begin
            c_e = m_pos % W;
            r_e = m_pos / W;
            img[m_pos] = d;
            m_pix = d;
            win_e = (r_e >= 2) && (c_e >= 2);
            if (win_e) exp_q.push_back({d, img[m_pos - W], img[m_pos - 2*W]});
            m_pos++;
            if (m_pos == W*H) begin
                m_in_frame  = 1'b0;
                m_pos       = 0;
                m_done_pend = 1'b1;
                m_frames++;
                fd_e = 1;
            end
        end
        #2;
        s_ready = in_ready;
        s_we    = lb0_we;
        s_addr  = lb0_addr;
        check("in_ready", in_ready, ready_e);
        check("lb0_we", lb0_we, wr);
        if (wr) begin
            check("lb0_addr", lb0_addr, c_e);
            check("lb0_din", lb0_din, d);
        end
        @(posedge clk);
        #1;
        check("lb1_we", lb1_we, wr);
        if (wr) check("lb1_addr", lb1_addr, c_e);
        check("win_valid", win_valid, win_e);
        if (win_e) begin
            check("col", col, c_e);
            check("row", row, r_e);
        end
        check("pix_d", pix_d, m_pix);
        check("resync", resync, res_e);
        check("frame_done", frame_done, fd_e);
        if (tap_pend) begin
            tap_pend = 1'b0;
            if (exp_q.size() == 0) begin
                fail_now("window_taps_unexpected");
            end else begin
                last_taps = {tap0, tap1, lb1_dout};
                check("window_taps", last_taps, exp_q.pop_front());
            end
        end
        if (win_valid) begin
            tap0 = pix_d;
            tap1 = lb0_dout;
            tap_pend = 1'b1;
            win_seen.push_back({row, col});
        end
    endtask

    task automatic send_frame_contig(input int base);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < W*H && guard < 100) begin
            acc = !m_done_pend;
            cycle(1'b1, idx == 0, 8'(base + idx));
            if (acc) idx++;
            guard++;
        end
        if (idx < W*H) fail_now("send_frame_timeout");
    endtask

    task automatic finish_frame();
        int guard = 0;
        while (m_in_frame && guard < 100) begin
            cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            guard++;
        end
        if (m_in_frame) fail_now("finish_frame_timeout");
    endtask

    task automatic check_win_list(input string p);
        check({p, "_win_count"}, win_seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < win_seen.size()) check({p, "_win_pos"}, win_seen[i], exp_win[i]);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit            v;
        bit            sof;
        logic [7:0]    d;
        bit            exp_we;
        logic [AW-1:0] exp_addr;
        bit            exp_win;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(bit v, bit sof, logic [7:0] d, bit we,
                                logic [AW-1:0] a, bit win);
        vec_t t;
        t.v = v; t.sof = sof; t.d = d; t.exp_we = we; t.exp_addr = a; t.exp_win = win;
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [21:0] list_a[$];
        int n;
        int guard;
        int f0;

        // Three IDLE beats without sof, then a contiguous 0..15 frame.
        tbl[0]  = mk(1, 0, 8'hA0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 8'hA1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 8'hA2, 0, 0, 0);
        tbl[3]  = mk(1, 1, 8'd0,  1, 0, 0);
        tbl[4]  = mk(1, 0, 8'd1,  1, 1, 0);
        tbl[5]  = mk(1, 0, 8'd2,  1, 2, 0);
        tbl[6]  = mk(1, 0, 8'd3,  1, 3, 0);
        tbl[7]  = mk(1, 0, 8'd4,  1, 0, 0);
        tbl[8]  = mk(1, 0, 8'd5,  1, 1, 0);
        tbl[9]  = mk(1, 0, 8'd6,  1, 2, 0);
        tbl[10] = mk(1, 0, 8'd7,  1, 3, 0);
        tbl[11] = mk(1, 0, 8'd8,  1, 0, 0);
        tbl[12] = mk(1, 0, 8'd9,  1, 1, 0);
        tbl[13] = mk(1, 0, 8'd10, 1, 2, 1);
        tbl[14] = mk(1, 0, 8'd11, 1, 3, 1);
        tbl[15] = mk(1, 0, 8'd12, 1, 0, 0);
        tbl[16] = mk(1, 0, 8'd13, 1, 1, 0);
        tbl[17] = mk(1, 0, 8'd14, 1, 2, 1);
        tbl[18] = mk(1, 0, 8'd15, 1, 3, 1);

        exp_win[0] = {11'd2, 11'd2};
        exp_win[1] = {11'd2, 11'd3};
        exp_win[2] = {11'd3, 11'd2};
        exp_win[3] = {11'd3, 11'd3};

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // --- table-driven frame ---
        win_seen.delete();
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].v, tbl[i].sof, tbl[i].d);
            check("tbl_we", s_we, tbl[i].exp_we);
            if (tbl[i].exp_we) check("tbl_addr", s_addr, tbl[i].exp_addr);
            check("tbl_win", win_valid, tbl[i].exp_win);
        end
        check("tbl_frame_done", frame_done, 1);
        cycle(1'b0, 1'b0, 8'h00);
        check("tbl_done_ready", s_ready, 0);
        check("tbl_taps_3_3", last_taps, 24'h0F0B07);
        check_win_list("tbl");
`ifdef LINE_BUF_CTRL_STATS_EN
        check("tbl_drop_cnt", drop_cnt, 3);
`endif
        cycle(1'b0, 1'b0, 8'h00);

        // --- in_valid toggling every cycle ---
        win_seen.delete();
        for (int i = 0; i < W*H; i++) begin
            cycle(1'b1, i == 0, 8'(3*i + 1));
            cycle(1'b0, 1'b0, 8'hEE);
            check("toggle_idle_we", s_we, 0);
            check("toggle_idle_win", win_valid, 0);
        end
        check_win_list("toggle");
        cycle(1'b0, 1'b0, 8'h00);

        // --- mid-frame sof on the 7th beat ---
        win_seen.delete();
        for (int i = 0; i < 6; i++) cycle(1'b1, i == 0, 8'(50 + i));
        cycle(1'b1, 1'b1, 8'd200);
        check("resync_pulse", resync, 1);
        n = 0;
        guard = 0;
        while (guard < 20) begin
            cycle(1'b1, 1'b0, 8'(201 + guard));
            guard++;
            if (win_valid) begin
                n = guard;
                break;
            end
        end
        check("resync_gap", n, 10);
        finish_frame();
`ifdef LINE_BUF_CTRL_STATS_EN
        check("resync_cnt", resync_cnt, m_resync);
        check("resync_cnt_one", resync_cnt, 1);
`endif
        cycle(1'b0, 1'b0, 8'h00);

        // --- reset during row 2 ---
        for (int i = 0; i < 9; i++) cycle(1'b1, i == 0, 8'(70 + i));
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        win_seen.delete();
        send_frame_contig(90);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check_win_list("after_reset");

        // --- back-to-back frames ---
        win_seen.delete();
        send_frame_contig(110);
        list_a = win_seen;
        win_seen.delete();
        send_frame_contig(130);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("b2b_count", win_seen.size(), list_a.size());
        for (int i = 0; i < 4; i++) begin
            if (i < win_seen.size() && i < list_a.size())
                check("b2b_win_pos", win_seen[i], list_a[i]);
        end
        check_win_list("b2b");

        // --- randomized frames with gaps, junk and occasional resync ---
        for (int f = 0; f < 8; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            f0 = m_frames;
            guard = 0;
            while (m_frames == f0 && guard < 400) begin
                cycle($urandom_range(0, 3) != 0,
                      m_in_frame ? ($urandom_range(0, 39) == 0) : 1'b1,
                      8'($urandom_range(0, 255)));
                guard++;
            end
            if (m_frames == f0) fail_now("random_frame_timeout");
        end
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
`ifdef LINE_BUF_CTRL_STATS_EN
        check("rand_drop_cnt", drop_cnt, m_drop);
        check("rand_resync_cnt", resync_cnt, m_resync);
`endif
        check("taps_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
